// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory operation from execute, drives a
// single-beat bus transaction with byte lanes, and returns an extended load result.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  LoadSrc,
  input  logic [1:0]  StoreSrc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t         state, state_nx;
  size_t          req_size, op_size;
  logic           req_unsigned, req_code_ok, req_aligned, req_legal;
  logic [3:0]     req_be;
  logic [31:0]    req_wdata;
  logic           op_load, op_unsigned, err_q;
  logic [1:0]     op_off;
  logic [CW-1:0]  cnt, cnt_inc;
  logic           tmo_hit;
  logic [7:0]     ld_byte;
  logic [15:0]    ld_half;
  logic [31:0]    load_data;

  // Request decode: width, signedness, legality and lane placement.
  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    req_size     = SZ_WORD;
    req_unsigned = 1'b0;
    req_code_ok  = 1'b0;
    if (is_load && !is_store) begin
      case (LoadSrc)
        3'b000: begin req_size = SZ_BYTE; req_code_ok = 1'b1; end
        3'b001: begin req_size = SZ_HALF; req_code_ok = 1'b1; end
        3'b010: begin req_size = SZ_WORD; req_code_ok = 1'b1; end
        3'b100: begin req_size = SZ_BYTE; req_code_ok = 1'b1; req_unsigned = 1'b1; end
        3'b101: begin req_size = SZ_HALF; req_code_ok = 1'b1; req_unsigned = 1'b1; end
        default: req_code_ok = 1'b0;
      endcase
    end else if (is_store && !is_load) begin
      case (StoreSrc)
        2'b00:   begin req_size = SZ_WORD; req_code_ok = 1'b1; end
        2'b01:   begin req_size = SZ_HALF; req_code_ok = 1'b1; end
        2'b10:   begin req_size = SZ_BYTE; req_code_ok = 1'b1; end
        default: req_code_ok = 1'b0;
      endcase
    end

    case (req_size)
      SZ_BYTE: begin
        req_aligned = 1'b1;
        req_be      = 4'b0001 << addr[1:0];
        req_wdata   = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        req_aligned = !addr[0];
        req_be      = 4'b0011 << addr[1:0];
        req_wdata   = {2{wdata[15:0]}};
      end
      default: begin
        req_aligned = (addr[1:0] == 2'b00);
        req_be      = 4'b1111;
        req_wdata   = wdata;
      end
    endcase
    req_legal = req_code_ok && req_aligned;
  end

  // Lane extraction for the returned load data.
  always_comb begin
    case (op_off)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = op_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_size)
      SZ_BYTE: load_data = op_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: load_data = op_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_data = mem_rdata;
    endcase
  end

  // An ack in the final cycle beats the timeout because mem_ack gates tmo_hit.
  assign cnt_inc = cnt + CW'(1);
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (state == REQ) && !mem_ack &&
                   (cnt_inc == CW'(TIMEOUT_CYCLES));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = req_legal ? REQ : DONE;
      REQ:     if (mem_ack || tmo_hit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_load     <= 1'b0;
      op_size     <= SZ_WORD;
      op_unsigned <= 1'b0;
      op_off      <= 2'b00;
      err_q       <= 1'b0;
      cnt         <= '0;
      rdata       <= 32'h0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'h0;
      mem_be      <= 4'h0;
      mem_wdata   <= 32'h0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op_load     <= is_load;
          op_size     <= req_size;
          op_unsigned <= req_unsigned;
          op_off      <= addr[1:0];
          err_q       <= !req_legal;
          cnt         <= '0;
          if (req_legal) begin
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_be    <= req_be;
            mem_wdata <= req_wdata;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (op_load) rdata <= load_data;
          end else if (tmo_hit) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign err  = done && err_q;

endmodule
